// File: rtl/return_router_if.sv
// return_router_if -- bundle of result-return signals between the shared
// resource, the two consumer pipelines and the return router.
//
// Signals:
//   rsp_valid / rsp_id / rsp_data : result from shared resource and its
//                                   destination channel (0 = pipe 1, 1 = pipe 2)
//   out_ready[1:0]                : per-channel consumer ready
//   flush_1 / flush_2             : per-channel flush
//   out_valid[1:0]                : per-channel head data present
//   out_data_1 / out_data_2       : per-channel head data
//   stall_1 / stall_2             : per-channel almost-full, masks arbiter request
//   overflow[1:0]                 : sticky per-channel drop error
//
// Modports: master drives results/ready/flush, slave is the router itself.
interface return_router_if #(
  parameter int DATA_W = 32
);
  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        out_ready;
  logic              flush_1;
  logic              flush_2;
  logic [1:0]        out_valid;
  logic [DATA_W-1:0] out_data_1;
  logic [DATA_W-1:0] out_data_2;
  logic              stall_1;
  logic              stall_2;
  logic [1:0]        overflow;

  modport master (
    output rsp_valid, rsp_id, rsp_data, out_ready, flush_1, flush_2,
    input  out_valid, out_data_1, out_data_2, stall_1, stall_2, overflow
  );

  modport slave (
    input  rsp_valid, rsp_id, rsp_data, out_ready, flush_1, flush_2,
    output out_valid, out_data_1, out_data_2, stall_1, stall_2, overflow
  );
endinterface

// File: rtl/return_router.sv
// return_router -- steers results from a shared resource back to one of two
// pipelines, each through its own first-word-fall-through FIFO.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-low (0 = reset)
//   bus   : return_router_if.slave (results in, per-channel head data out,
//           stall/overflow status)
//
// Parameters:
//   DATA_W : result width
//   DEPTH  : entries per channel FIFO, power of two, >= 2
module return_router #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  return_router_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_CNT = CNT_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [2][DEPTH];
  logic [PTR_W-1:0]  wptr [2];
  logic [PTR_W-1:0]  rptr [2];
  logic [CNT_W-1:0]  count [2];
  logic [CNT_W-1:0]  count_next [2];
  logic [1:0]        stall_q;
  logic [1:0]        overflow_q;

  logic [1:0] flush;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] drop;

  assign flush = {bus.flush_2, bus.flush_1};

  // Per-channel push/pop/drop decisions. A full channel drops even if it is
  // popped this cycle, and flush suppresses everything including the
  // overflow flag of a push it discards.
  always_comb begin
    push = '0;
    pop  = '0;
    drop = '0;
    for (int ch = 0; ch < 2; ch++) begin
      count_next[ch] = count[ch];
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (!flush[ch]) begin
        if (bus.rsp_valid && (bus.rsp_id == 1'(ch))) begin
          if (count[ch] == FULL_CNT) begin
            drop[ch] = 1'b1;
          end else begin
            push[ch] = 1'b1;
          end
        end
        pop[ch] = (count[ch] != '0) && bus.out_ready[ch];
      end
      if (flush[ch]) begin
        count_next[ch] = '0;
      end else begin
        count_next[ch] = count[ch] + CNT_W'(push[ch]) - CNT_W'(pop[ch]);
      end
    end
  end

  // Control state: counts, pointers, registered almost-full and sticky
  // overflow. Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        count[ch] <= '0;
        wptr[ch]  <= '0;
        rptr[ch]  <= '0;
      end
      stall_q    <= '0;
      overflow_q <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        count[ch]   <= count_next[ch];
        stall_q[ch] <= (count_next[ch] >= ALMOST_CNT);
        if (flush[ch]) begin
          wptr[ch] <= '0;
          rptr[ch] <= '0;
        end else begin
          if (push[ch]) begin
            wptr[ch] <= wptr[ch] + 1'b1;
          end
          if (pop[ch]) begin
            rptr[ch] <= rptr[ch] + 1'b1;
          end
        end
        if (drop[ch]) begin
          overflow_q[ch] <= 1'b1;
        end
      end
    end
  end

  // Storage has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (reset && push[ch]) begin
        mem[ch][wptr[ch]] <= bus.rsp_data;
      end
    end
  end

  assign bus.out_valid  = {(count[1] != '0), (count[0] != '0)};
  assign bus.out_data_1 = mem[0][rptr[0]];
  assign bus.out_data_2 = mem[1][rptr[1]];
  assign bus.stall_1    = stall_q[0];
  assign bus.stall_2    = stall_q[1];
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_return_router.sv
// tb_return_router -- directed self-checking bench for return_router
// (DATA_W = 32, DEPTH = 4). Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, away from the edge.
module tb_return_router;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  return_router_if #(.DATA_W(32)) bus ();

  return_router #(.DATA_W(32), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rsp_valid = 1'b0;
    bus.rsp_id    = 1'b0;
    bus.rsp_data  = '0;
    bus.out_ready = 2'b00;
    bus.flush_1   = 1'b0;
    bus.flush_2   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++;
    if (bus.out_valid !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_valid: got %b expected 00", bus.out_valid);
    end
    total++;
    if ({bus.stall_2, bus.stall_1} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_stall: got %b expected 00", {bus.stall_2, bus.stall_1});
    end
    total++;
    if (bus.overflow !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_overflow: got %b expected 00", bus.overflow);
    end
    // ready on empty channels must do nothing
    bus.out_ready = 2'b11;
    tick();
    bus.out_ready = 2'b00;
    total++;
    if (bus.out_valid !== 2'b00) begin
      bad++;
      $display("[TB] FAIL empty_ready: got %b expected 00", bus.out_valid);
    end
  endtask

  task automatic test_single();
    bus.rsp_valid = 1'b1;
    bus.rsp_id    = 1'b0;
    bus.rsp_data  = 32'hA1;
    tick();
    bus.rsp_valid = 1'b0;
    total++;
    if (bus.out_valid !== 2'b01) begin
      bad++;
      $display("[TB] FAIL single_valid: got %b expected 01", bus.out_valid);
    end
    total++;
    if (bus.out_data_1 !== 32'hA1) begin
      bad++;
      $display("[TB] FAIL single_data: got %h expected a1", bus.out_data_1);
    end
    bus.out_ready = 2'b01;
    tick();
    bus.out_ready = 2'b00;
    total++;
    if (bus.out_valid !== 2'b00) begin
      bad++;
      $display("[TB] FAIL single_pop: got %b expected 00", bus.out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_stall [5];
    exp_stall = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_id    = 1'b1;
      bus.rsp_data  = 32'h10 + k;
      tick();
      total++;
      if (bus.stall_2 !== exp_stall[k][0]) begin
        bad++;
        $display("[TB] FAIL ovf_stall_push%0d: got %b expected %b", k, bus.stall_2, exp_stall[k][0]);
      end
      total++;
      if (bus.overflow !== ((k == 4) ? 2'b10 : 2'b00)) begin
        bad++;
        $display("[TB] FAIL ovf_flag_push%0d: got %b expected %b", k, bus.overflow, (k == 4) ? 2'b10 : 2'b00);
      end
    end
    bus.rsp_valid = 1'b0;
    bus.out_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.out_valid[1] !== 1'b1 || bus.out_data_2 !== 32'h10 + i) begin
        bad++;
        $display("[TB] FAIL ovf_drain%0d: got v=%b d=%h expected v=1 d=%h", i, bus.out_valid[1], bus.out_data_2, 32'h10 + i);
      end
      tick();
      total++;
      if (bus.stall_2 !== (i == 0)) begin
        bad++;
        $display("[TB] FAIL ovf_drain_stall%0d: got %b expected %b", i, bus.stall_2, (i == 0));
      end
    end
    bus.out_ready = 2'b00;
    total++;
    if (bus.out_valid !== 2'b00 || bus.overflow !== 2'b10) begin
      bad++;
      $display("[TB] FAIL ovf_after_drain: got v=%b o=%b expected v=00 o=10", bus.out_valid, bus.overflow);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] q [$];
    for (int i = 0; i < 3; i++) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_id    = 1'b0;
      bus.rsp_data  = 32'h20 + i;
      q.push_back(32'h20 + i);
      tick();
    end
    total++;
    if (bus.stall_1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wrap_fill_stall: got %b expected 1", bus.stall_1);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bus.out_data_1 !== q[0]) begin
        bad++;
        $display("[TB] FAIL wrap_head%0d: got %h expected %h", i, bus.out_data_1, q[0]);
      end
      bus.rsp_data  = 32'h23 + i;
      bus.out_ready = 2'b01;
      tick();
      void'(q.pop_front());
      q.push_back(32'h23 + i);
      total++;
      if (bus.out_valid[0] !== 1'b1 || bus.stall_1 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL wrap_level%0d: got v=%b s=%b expected v=1 s=1", i, bus.out_valid[0], bus.stall_1);
      end
    end
    bus.rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.out_data_1 !== q[0]) begin
        bad++;
        $display("[TB] FAIL wrap_drain%0d: got %h expected %h", i, bus.out_data_1, q[0]);
      end
      tick();
      void'(q.pop_front());
    end
    bus.out_ready = 2'b00;
    total++;
    if (bus.out_valid !== 2'b00) begin
      bad++;
      $display("[TB] FAIL wrap_empty: got %b expected 00", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.rsp_valid = 1'b1;
    bus.rsp_id    = 1'b1;
    bus.rsp_data  = 32'h55;
    tick();
    bus.rsp_id   = 1'b0;
    bus.rsp_data = 32'h30;
    tick();
    bus.rsp_data = 32'h31;
    tick();
    bus.rsp_data = 32'h32;
    bus.flush_1  = 1'b1;
    tick();
    bus.flush_1   = 1'b0;
    bus.rsp_valid = 1'b0;
    total++;
    if (bus.out_valid !== 2'b10) begin
      bad++;
      $display("[TB] FAIL flush_valid: got %b expected 10", bus.out_valid);
    end
    total++;
    if (bus.overflow !== 2'b10) begin
      bad++;
      $display("[TB] FAIL flush_overflow: got %b expected 10", bus.overflow);
    end
    total++;
    if (bus.out_data_2 !== 32'h55) begin
      bad++;
      $display("[TB] FAIL flush_other_ch: got %h expected 55", bus.out_data_2);
    end
    // flushing a full channel while pushing must not flag overflow
    bus.rsp_valid = 1'b1;
    bus.rsp_id    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.rsp_data = 32'h60 + i;
      tick();
    end
    bus.rsp_data = 32'h64;
    bus.flush_1  = 1'b1;
    tick();
    bus.flush_1   = 1'b0;
    bus.rsp_valid = 1'b0;
    total++;
    if (bus.out_valid !== 2'b10 || bus.overflow !== 2'b10 || bus.stall_1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_full: got v=%b o=%b s=%b expected v=10 o=10 s=0", bus.out_valid, bus.overflow, bus.stall_1);
    end
    bus.out_ready = 2'b10;
    tick();
    bus.out_ready = 2'b00;
    total++;
    if (bus.out_valid !== 2'b00) begin
      bad++;
      $display("[TB] FAIL flush_cleanup: got %b expected 00", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_id    = 1'(i % 2);
      bus.rsp_data  = 32'h40 + i;
      tick();
      total++;
      if (bus.out_valid !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        bad++;
        $display("[TB] FAIL b2b_valid%0d: got %b expected %b", i, bus.out_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      total++;
      if (((i % 2 == 0) ? bus.out_data_1 : bus.out_data_2) !== 32'h40 + i) begin
        bad++;
        $display("[TB] FAIL b2b_data%0d: got %h/%h expected %h", i, bus.out_data_1, bus.out_data_2, 32'h40 + i);
      end
      total++;
      if ({bus.stall_2, bus.stall_1} !== 2'b00) begin
        bad++;
        $display("[TB] FAIL b2b_stall%0d: got %b expected 00", i, {bus.stall_2, bus.stall_1});
      end
    end
    bus.rsp_valid = 1'b0;
    tick();
    bus.out_ready = 2'b00;
    total++;
    if (bus.out_valid !== 2'b00) begin
      bad++;
      $display("[TB] FAIL b2b_empty: got %b expected 00", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.rsp_valid = 1'b1;
    bus.rsp_id    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.rsp_data = 32'h70 + i;
      tick();
    end
    bus.rsp_id   = 1'b1;
    bus.rsp_data = 32'h7F;
    tick();
    total++;
    if (bus.overflow !== 2'b11 || bus.out_valid !== 2'b11) begin
      bad++;
      $display("[TB] FAIL rstmid_setup: got o=%b v=%b expected o=11 v=11", bus.overflow, bus.out_valid);
    end
    // push held during reset must be discarded
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.rsp_valid = 1'b0;
    total++;
    if (bus.out_valid !== 2'b00 || bus.overflow !== 2'b00 || {bus.stall_2, bus.stall_1} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL rstmid_clear: got v=%b o=%b s=%b expected all 0", bus.out_valid, bus.overflow, {bus.stall_2, bus.stall_1});
    end
    tick();
    total++;
    if (bus.out_valid !== 2'b00) begin
      bad++;
      $display("[TB] FAIL rstmid_quiet: got %b expected 00", bus.out_valid);
    end
    bus.rsp_valid = 1'b1;
    bus.rsp_id    = 1'b0;
    bus.rsp_data  = 32'h77;
    tick();
    bus.rsp_valid = 1'b0;
    total++;
    if (bus.out_valid !== 2'b01 || bus.out_data_1 !== 32'h77) begin
      bad++;
      $display("[TB] FAIL rstmid_push: got v=%b d=%h expected v=01 d=77", bus.out_valid, bus.out_data_1);
    end
    bus.out_ready = 2'b01;
    tick();
    bus.out_ready = 2'b00;
    total++;
    if (bus.out_valid !== 2'b00) begin
      bad++;
      $display("[TB] FAIL rstmid_pop: got %b expected 00", bus.out_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_single();
    test_overflow();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/return_router.md
RETURN_ROUTER -- requirements
Module: return_router

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning the result data width.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning per-channel FIFO entries; legal values are a power of two, at least 2.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-005 The module SHALL have port rsp_valid, input, 1 bit: a result from the shared resource is present this cycle.
REQ-006 The module SHALL have port rsp_id, input, 1 bit: destination channel (0 = pipeline 1, 1 = pipeline 2).
REQ-007 The module SHALL have port rsp_data, input, DATA_W bits: the result payload.
REQ-008 The module SHALL have port out_ready, input, 2 bits: consumer ready, where bit n is channel n.
REQ-009 The module SHALL have ports flush_1 and flush_2, input, 1 bit each: per-channel flush.
REQ-010 The module SHALL have port out_valid, output, 2 bits: channel n has head data.
REQ-011 The module SHALL have ports out_data_1 and out_data_2, output, DATA_W bits each: channel head data.
REQ-012 The module SHALL have ports stall_1 and stall_2, output, 1 bit each: channel almost full; the arbiter masks that channel's request while it is high.
REQ-013 The module SHALL have port overflow, output, 2 bits: sticky per-channel drop error.

Function
REQ-014 Each channel SHALL hold an independent first-word-fall-through FIFO with write pointer, read pointer and a count in the range 0..DEPTH.
REQ-015 A push to channel rsp_id SHALL occur when rsp_valid=1 and count<DEPTH; data is written at wptr, and wptr increments modulo DEPTH.
REQ-016 When rsp_valid=1 and the target count=DEPTH, the result SHALL be dropped, overflow[rsp_id] set, and FIFO state left unchanged; a same-cycle pop does not make room.
REQ-017 out_valid[n] SHALL equal (count_n != 0), combinationally from registered state.
REQ-018 out_data_n SHALL equal mem_n[rptr_n] with zero-cycle read latency; its value is don't-care when out_valid[n]=0.
REQ-019 A pop on channel n SHALL occur when out_valid[n]=1 and out_ready[n]=1; rptr increments modulo DEPTH.
REQ-020 On simultaneous push and pop on the same channel with 0<count<DEPTH, count SHALL be unchanged and both pointers SHALL advance.
REQ-021 out_ready[n] while out_valid[n]=0 SHALL have no effect.
REQ-022 stall_n SHALL be registered and SHALL equal 1 in cycle t+1 iff count_n >= DEPTH-1 after the cycle-t update.
REQ-023 flush_n=1 SHALL set count_n, wptr_n and rptr_n to 0 at the next edge.
REQ-024 flush_n SHALL take priority over a same-cycle push or pop on channel n; a dropped push due to flush SHALL NOT set overflow.
REQ-025 flush_n SHALL NOT clear overflow[n] and SHALL NOT affect the other channel.
REQ-026 The minimum result latency SHALL be 1 cycle: a push at edge t gives out_valid=1 in cycle t+1.
REQ-027 A full FIFO fill followed by a drain SHALL return data in push order across pointer wrap-around.

Reset
REQ-028 When reset=0 at a rising edge, all counts and pointers SHALL be set to 0, out_valid=2'b00, stall_1=stall_2=0 and overflow=2'b00.
REQ-029 FIFO storage SHALL NOT require reset.
REQ-030 Reset SHALL take priority over flush, push and pop.
REQ-031 Reset asserted mid-stream SHALL discard all entries, with no output activity in the first cycle after release.

Verification
REQ-032 Bench SHALL cover: push 0xA1 to ch0, out_ready=0 -> out_valid=01, out_data_1=0xA1 next cycle; out_ready[0]=1 -> out_valid=00 following cycle.
REQ-033 Bench SHALL cover: push 5 results (0x10..0x14) to ch1 with DEPTH=4, ready=0 -> stall_2=1 after the 3rd push, overflow=10 after the 5th; drain yields 0x10..0x13 in order.
REQ-034 Bench SHALL cover: fill ch0 to 3 entries, then push and pop in the same cycle -> count stays 3, order preserved through wrap; repeat 8 cycles with no loss.
REQ-035 Bench SHALL cover: ch0 holding 2 entries with flush_1=1 and a ch0 push in the same cycle -> out_valid[0]=0 next cycle, overflow[0]=0, ch1 contents intact.
REQ-036 Bench SHALL cover: alternate rsp_id 0/1 for 6 cycles with both readies=1 -> each channel delivers its 3 values in order, 1-cycle latency, stall never asserted.
REQ-037 Bench SHALL cover: reset=0 for 1 cycle while both FIFOs are non-empty and overflow=11 -> all outputs 0 after the edge; a push the cycle after release is delivered normally.
